banked_sync_ram: RTL

Parametrised multi-lane synchronous RAM with a request/response handshake, per-lane write enables, a configurable read latency of 1 or 2 cycles, and a hardware clear engine. It is the next generation of the team's lane-sliced memory: one generated bank per lane, a shared address, and registered read data. It sits between a bus-side requester and on-chip storage, and is the standard scratch/buffer memory for new datapaths.

---
 rtl/banked_ram_pkg.sv | 30 +++
 rtl/ram_lane.sv | 33 +++
 rtl/banked_sync_ram.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/banked_ram_pkg.sv
// Shared types and helpers for the banked synchronous RAM.
// Holds the controller state encoding, the legal read latencies and lane slicing.
package banked_ram_pkg;

    typedef enum logic [1:0] {
        INIT,
        CLEAR,
        RUN
    } bram_state_e;

    localparam int unsigned RD_LAT_SHORT = 1;
    localparam int unsigned RD_LAT_LONG  = 2;

    // Upper bound on LANES*LANE_W accepted by lane_slice
    localparam int unsigned MAX_DATA_W = 1024;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat == RD_LAT_SHORT) || (lat == RD_LAT_LONG);
    endfunction

    // Returns lane idx in the low bits; the caller truncates to its lane width
    function automatic logic [MAX_DATA_W-1:0] lane_slice(
        input logic [MAX_DATA_W-1:0] data,
        input int unsigned           idx,
        input int unsigned           lane_w
    );
        return data >> (idx * lane_w);
    endfunction

endpackage

// File: rtl/ram_lane.sv
// One lane of the banked RAM: LANE_W x DEPTH storage with a registered read port.
// The read register holds its value until the next read.
module ram_lane #(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/banked_sync_ram.sv
// Multi-lane synchronous RAM with request/response handshake, per-lane write enables,
// 1- or 2-cycle read latency and a hardware clear engine sequenced by a small FSM.
module banked_sync_ram
    import banked_ram_pkg::*;
#(
    parameter int unsigned LANES          = 4,
    parameter int unsigned LANE_W         = 8,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned DW            = LANES * LANE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [LANES-1:0] req_be,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy
);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("banked_sync_ram: RD_LAT must be 1 or 2");
    end
    if (LANES < 1 || DW > MAX_DATA_W) begin : g_bad_lanes
        $error("banked_sync_ram: LANES must be >= 1 and LANES*LANE_W within MAX_DATA_W");
    end

    bram_state_e   state, state_nxt;
    logic [AW-1:0] clr_ptr, clr_ptr_nxt;
    logic          ready_q, busy_q;

    logic          accept, in_range, rd_fire, wr_fire, clearing;
    logic [AW-1:0] lane_addr;
    logic [DW-1:0] lane_rdata;
    logic [DW-1:0] rd_data1;
    logic          v1, oor1;

    assign accept    = req_valid & ready_q;
    assign in_range  = 32'(req_addr) < DEPTH;
    assign rd_fire   = accept & ~req_write;
    assign wr_fire   = accept & req_write & in_range;
    assign clearing  = (state == CLEAR);
    assign lane_addr = clearing ? clr_ptr : req_addr;

    assign req_ready = ready_q;
    assign busy      = busy_q;

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            INIT: begin
                state_nxt   = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
                clr_ptr_nxt = '0;
            end
            CLEAR: begin
                if (clr_ptr == AW'(DEPTH - 1)) begin
                    state_nxt   = RUN;
                    clr_ptr_nxt = '0;
                end else begin
                    clr_ptr_nxt = clr_ptr + AW'(1);
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt   = INIT;
                clr_ptr_nxt = '0;
            end
        endcase
    end

    // ready/busy are registered from the next state so they track state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_ptr <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            ready_q <= (state_nxt == RUN);
            busy_q  <= (state_nxt == CLEAR);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic              lane_we;
        logic [LANE_W-1:0] lane_wdata;

        assign lane_we    = clearing | (wr_fire & req_be[k]);
        assign lane_wdata = clearing ? '0
                          : LANE_W'(lane_slice(MAX_DATA_W'(req_wdata), k, LANE_W));

        ram_lane #(
            .LANE_W(LANE_W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (lane_we),
            .re   (rd_fire & in_range),
            .addr (lane_addr),
            .wdata(lane_wdata),
            .rdata(lane_rdata[k*LANE_W +: LANE_W])
        );
    end

    // Out-of-range reads leave the lane registers untouched and are zeroed here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            oor1 <= 1'b0;
        end else begin
            v1 <= rd_fire;
            if (rd_fire) begin
                oor1 <= ~in_range;
            end
        end
    end

    assign rd_data1 = oor1 ? '0 : lane_rdata;

    if (RD_LAT == RD_LAT_SHORT) begin : g_lat1
        assign rsp_valid = v1;
        assign rsp_rdata = rd_data1;
    end else begin : g_lat2
        logic          v2;
        logic [DW-1:0] data2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2    <= 1'b0;
                data2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    data2 <= rd_data1;
                end
            end
        end

        assign rsp_valid = v2;
        assign rsp_rdata = data2;
    end

endmodule
